// File: rtl/weight_pkg.sv
// ---------------------------------------------------------------------------
// weight_pkg
// Shared constants and types for the grams-to-kilograms conversion path.
//   W_DEFAULT   : default width of the gram sample and both result fields
//   KG_DIVISOR  : grams per kilogram
//   conv_state_e: sequencing states of weight_conv_ctrl
//   iter_width  : width of a counter that must hold the values 0..w-1
// ---------------------------------------------------------------------------
package weight_pkg;

    localparam int W_DEFAULT  = 14;
    localparam int KG_DIVISOR = 1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } conv_state_e;

    // Never returns less than 1, so a counter declared with it is always a
    // real vector even for the smallest legal widths.
    function automatic int iter_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/weight_conv_ctrl_div_step.sv
// ---------------------------------------------------------------------------
// restoring_div_step
// One purely combinational step of an MSB-first restoring division.
// Ports:
//   rem          in  W  partial remainder from the previous step (< divisor)
//   dividend_bit in  1  next dividend bit, shifted into the remainder LSB
//   divisor      in  W  nonzero divisor
//   rem_next     out W  partial remainder after this step (< divisor)
//   q_bit        out 1  quotient bit produced by this step
// ---------------------------------------------------------------------------
module restoring_div_step #(
    parameter int W = 14
) (
    input  logic [W-1:0] rem,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   shifted;
    logic [W-1:0] diff;

    // The shifted remainder is kept one bit wider so the compare stays exact
    // even when the divisor lies in the upper half of the W-bit range.
    assign shifted = {rem, dividend_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});

    // When q_bit is set the true difference is below the divisor and so fits
    // in W bits; modulo-2^W subtraction therefore yields it exactly.
    assign diff     = shifted[W-1:0] - divisor;
    assign rem_next = q_bit ? diff : shifted[W-1:0];

endmodule

// File: rtl/weight_conv_ctrl.sv
// ---------------------------------------------------------------------------
// weight_conv_ctrl
// Sequencing controller that turns a raw gram sample into kilograms plus a
// gram remainder. An optional tare offset is subtracted first; negative net
// weights are clamped to zero and flagged. The division by DIVISOR is a
// restoring divider, one bit per cycle, sharing a single step unit.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        sample handshake (ready only while idle)
//   weightInGrams [W]          unsigned raw sample in grams
//   tare                       accepted sample becomes the tare value
//   clr_tare                   single-cycle pulse zeroing the tare value
//   tare_active                tare value is nonzero
//   out_valid / out_ready      result handshake
//   weightInKilogramsInteger   net grams / DIVISOR
//   weightInKilogramsFraction  net grams % DIVISOR
//   underweight                net weight was negative and clamped to 0
// A sample accepted on edge N gives LOAD in the following cycle, W cycles
// of DIV, and a result visible in the (W+2)-th cycle after acceptance.
// ---------------------------------------------------------------------------
module weight_conv_ctrl
    import weight_pkg::*;
#(
    parameter int W       = W_DEFAULT,
    parameter int DIVISOR = KG_DIVISOR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] weightInGrams,
    input  logic         tare,
    input  logic         clr_tare,
    output logic         tare_active,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] weightInKilogramsInteger,
    output logic [W-1:0] weightInKilogramsFraction,
    output logic         underweight
);

    localparam int            IW        = iter_width(W);
    localparam logic [W-1:0]  DIV_VEC   = W'(DIVISOR);
    localparam logic [IW-1:0] ITER_LAST = IW'(W - 1);

    conv_state_e   state_q, state_d;
    logic [W-1:0]  sample_q, sample_d;
    logic [W-1:0]  tare_q, tare_d;
    logic          tare_active_q, tare_active_d;
    logic [W-1:0]  dividend_q, dividend_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          uw_pend_q, uw_pend_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  kg_int_q, kg_int_d;
    logic [W-1:0]  kg_frac_q, kg_frac_d;
    logic          underweight_q, underweight_d;

    logic signed [W:0] net;
    logic [W-1:0]      step_rem;
    logic              step_bit;

    // Net weight with one extra sign bit so any sample/tare pair is exact.
    assign net = $signed({1'b0, sample_q}) - $signed({1'b0, tare_q});

    restoring_div_step #(
        .W(W)
    ) u_step (
        .rem          (rem_q),
        .dividend_bit (dividend_q[iter_q]),
        .divisor      (DIV_VEC),
        .rem_next     (step_rem),
        .q_bit        (step_bit)
    );

    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        tare_d        = tare_q;
        dividend_d    = dividend_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        iter_d        = iter_q;
        uw_pend_d     = uw_pend_q;
        out_valid_d   = out_valid_q;
        kg_int_d      = kg_int_q;
        kg_frac_d     = kg_frac_q;
        underweight_d = underweight_q;

        // Clearing is honoured in every state; a tare capture below
        // overrides it because it is assigned later.
        if (clr_tare) begin
            tare_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (tare) begin
                        tare_d = weightInGrams;
                    end else begin
                        sample_d = weightInGrams;
                        state_d  = LOAD;
                    end
                end
            end

            // The tare value is consumed here, so a later clear cannot
            // change the conversion already in flight.
            LOAD: begin
                if (net[W]) begin
                    dividend_d = '0;
                    uw_pend_d  = 1'b1;
                end else begin
                    dividend_d = net[W-1:0];
                    uw_pend_d  = 1'b0;
                end
                rem_d   = '0;
                quo_d   = '0;
                iter_d  = ITER_LAST;
                state_d = DIV;
            end

            // The final step writes the result registers directly, so the
            // outputs are ready on the same edge that enters DONE.
            DIV: begin
                rem_d         = step_rem;
                quo_d[iter_q] = step_bit;
                if (iter_q == '0) begin
                    kg_int_d      = quo_d;
                    kg_frac_d     = step_rem;
                    underweight_d = uw_pend_q;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end else begin
                    iter_d = iter_q - 1'b1;
                end
            end

            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d    = (state_d == IDLE);
        tare_active_d = |tare_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sample_q      <= '0;
            tare_q        <= '0;
            tare_active_q <= 1'b0;
            dividend_q    <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            iter_q        <= '0;
            uw_pend_q     <= 1'b0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            kg_int_q      <= '0;
            kg_frac_q     <= '0;
            underweight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_q      <= sample_d;
            tare_q        <= tare_d;
            tare_active_q <= tare_active_d;
            dividend_q    <= dividend_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            iter_q        <= iter_d;
            uw_pend_q     <= uw_pend_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            kg_int_q      <= kg_int_d;
            kg_frac_q     <= kg_frac_d;
            underweight_q <= underweight_d;
        end
    end

    assign in_ready                  = in_ready_q;
    assign out_valid                 = out_valid_q;
    assign tare_active               = tare_active_q;
    assign weightInKilogramsInteger  = kg_int_q;
    assign weightInKilogramsFraction = kg_frac_q;
    assign underweight               = underweight_q;

endmodule

// File: tb/tb_weight_conv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weight_conv_ctrl
// Scoreboard bench for weight_conv_ctrl: every accepted measurement pushes
// its expected kilogram/gram/underweight triple, computed from a local tare
// model, and each produced result pops and compares against it.
// ---------------------------------------------------------------------------
module tb_weight_conv_ctrl;

    localparam int W = 14;

    typedef struct {
        int kg;
        int g;
        int uw;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] weightInGrams;
    logic         tare;
    logic         clr_tare;
    logic         tare_active;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] weightInKilogramsInteger;
    logic [W-1:0] weightInKilogramsFraction;
    logic         underweight;

    exp_t sbQ[$];
    int   modelTare;
    int   vectorCount;
    int   missCount;

    weight_conv_ctrl #(
        .W       (W),
        .DIVISOR (1000)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .in_valid                  (in_valid),
        .in_ready                  (in_ready),
        .weightInGrams             (weightInGrams),
        .tare                      (tare),
        .clr_tare                  (clr_tare),
        .tare_active               (tare_active),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .weightInKilogramsInteger  (weightInKilogramsInteger),
        .weightInKilogramsFraction (weightInKilogramsFraction),
        .underweight               (underweight)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single point of comparison: counts the vector and reports a miscompare
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference result for a sample against the current model tare
    function automatic exp_t modelConvert(input int w);
        exp_t e;
        int   net;
        net = w - modelTare;
        e.uw = (net < 0) ? 1 : 0;
        if (net < 0) net = 0;
        e.kg = net / 1000;
        e.g  = net % 1000;
        return e;
    endfunction

    // Presents a sample, waits (bounded) until it is taken, updates the model
    task automatic applyStimulus(input int w, input bit isTare, input bit pushExp);
        int waitCycles;
        @(negedge clk);
        in_valid      = 1'b1;
        weightInGrams = W'(w);
        tare          = isTare;
        waitCycles    = 0;
        while (!in_ready && waitCycles < 60) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!in_ready) begin
            checkOutput("in_ready_timeout", int'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tare     = 1'b0;
        if (isTare) begin
            modelTare = w;
        end else if (pushExp) begin
            sbQ.push_back(modelConvert(w));
        end
    endtask

    // Waits for the result counting cycles since acceptance, compares it,
    // optionally holds back out_ready, then completes the handshake
    task automatic collectResult(input int elapsed, input int holdCycles);
        int   cnt;
        exp_t e;
        cnt = elapsed;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 40);
        checkOutput("latency", cnt, 16);
        checkOutput("in_ready_busy", int'(in_ready), 0);
        checkOutput("sb_depth", sbQ.size(), 1);
        e = '{kg: 0, g: 0, uw: 0};
        if (sbQ.size() > 0) e = sbQ.pop_front();
        checkOutput("kg_int", int'(weightInKilogramsInteger), e.kg);
        checkOutput("kg_frac", int'(weightInKilogramsFraction), e.g);
        checkOutput("underweight", int'(underweight), e.uw);
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", int'(out_valid), 1);
            checkOutput("hold_in_ready", int'(in_ready), 0);
            checkOutput("hold_int", int'(weightInKilogramsInteger), e.kg);
            checkOutput("hold_frac", int'(weightInKilogramsFraction), e.g);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_valid", int'(out_valid), 0);
        checkOutput("post_in_ready", int'(in_ready), 1);
        checkOutput("post_int", int'(weightInKilogramsInteger), e.kg);
        checkOutput("post_frac", int'(weightInKilogramsFraction), e.g);
    endtask

    // Reset-value check shared by power-up and the mid-conversion reset
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
        checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
        checkOutput({tag, "_tare_active"}, int'(tare_active), 0);
        checkOutput({tag, "_underweight"}, int'(underweight), 0);
        checkOutput({tag, "_int"}, int'(weightInKilogramsInteger), 0);
        checkOutput({tag, "_frac"}, int'(weightInKilogramsFraction), 0);
    endtask

    // Main sequence
    initial begin
        int tw;
        int sw;
        vectorCount   = 0;
        missCount     = 0;
        modelTare     = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        weightInGrams = '0;
        tare          = 1'b0;
        clr_tare      = 1'b0;
        out_ready     = 1'b1;

        #12;
        checkResetState("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain conversion
        applyStimulus(1500, 1'b0, 1'b1);
        collectResult(0, 0);

        // Tare 200
        applyStimulus(200, 1'b1, 1'b0);
        checkOutput("tare_active_set", int'(tare_active), 1);
        applyStimulus(1500, 1'b0, 1'b1);
        collectResult(0, 0);

        // Tare above the sample clamps to zero
        applyStimulus(2000, 1'b1, 1'b0);
        applyStimulus(1500, 1'b0, 1'b1);
        collectResult(0, 0);

        // Clear tare then full-scale sample
        @(negedge clk);
        clr_tare = 1'b1;
        @(posedge clk);
        #1;
        clr_tare  = 1'b0;
        modelTare = 0;
        checkOutput("tare_active_clr", int'(tare_active), 0);
        applyStimulus(16383, 1'b0, 1'b1);
        collectResult(0, 0);
        checkOutput("tare_active_after", int'(tare_active), 0);

        // Backpressure with a second sample waiting at the input
        out_ready = 1'b0;
        applyStimulus(999, 1'b0, 1'b1);
        in_valid      = 1'b1;
        weightInGrams = W'(2500);
        collectResult(0, 10);
        applyStimulus(2500, 1'b0, 1'b1);
        collectResult(0, 0);

        // Reset in the middle of the division (iteration 7)
        applyStimulus(300, 1'b1, 1'b0);
        applyStimulus(5000, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkResetState("midreset");
        @(negedge clk);
        rst_n     = 1'b1;
        modelTare = 0;
        applyStimulus(1000, 1'b0, 1'b1);
        collectResult(0, 0);

        // Boundary samples
        applyStimulus(0, 1'b0, 1'b1);
        collectResult(0, 0);
        applyStimulus(1000, 1'b0, 1'b1);
        collectResult(0, 0);
        applyStimulus(999, 1'b0, 1'b1);
        collectResult(0, 0);

        // Clear during DIV: current result keeps the old tare
        applyStimulus(100, 1'b1, 1'b0);
        applyStimulus(1100, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        clr_tare = 1'b1;
        @(posedge clk);
        #1;
        clr_tare  = 1'b0;
        modelTare = 0;
        collectResult(3, 0);
        checkOutput("tare_active_midclr", int'(tare_active), 0);
        applyStimulus(1100, 1'b0, 1'b1);
        collectResult(0, 0);

        // A few random tare/sample pairs
        for (int k = 0; k < 4; k++) begin
            tw = int'($urandom_range(0, 3000));
            sw = int'($urandom_range(0, 16383));
            applyStimulus(tw, 1'b1, 1'b0);
            checkOutput("tare_active_rand", int'(tare_active), (tw != 0) ? 1 : 0);
            applyStimulus(sw, 1'b0, 1'b1);
            collectResult(0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
